// File: rtl/vdg_address_gen_if.sv
// vdg_address_gen_if: VDG timing/mode inputs and video RAM address outputs of the SAM address counter
interface vdg_address_gen_if #(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 7
) ();
  logic                    da0;
  logic                    hsn;
  logic                    fsn;
  logic                    ang;
  logic [2:0]              gm;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    addr_strobe;
  logic [3:0]              line_count;
  modport master (
    output da0, hsn, fsn, ang, gm, offset,
    input  addr, addr_strobe, line_count
  );
  modport slave (
    input  da0, hsn, fsn, ang, gm, offset,
    output addr, addr_strobe, line_count
  );
endinterface

// File: rtl/vdg_address_gen.sv
// vdg_address_gen: video RAM display address counter with per-mode scanline repeat
module vdg_address_gen #(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 7,
  parameter int ALPHA_ROWS   = 12
) (
  input logic              Clk,
  input logic              Reset,
  vdg_address_gen_if.slave bus
);
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [3:0]            line_count_q, line_count_d, last_line;
  logic                  strobe_q, strobe_d;
  logic                  da0_h_q, hsn_h_q, fsn_h_q;
  logic                  da0_fall, hsn_fall, fsn_fall;
  assign da0_fall = da0_h_q & ~bus.da0;
  assign hsn_fall = hsn_h_q & ~bus.hsn;
  assign fsn_fall = fsn_h_q & ~bus.fsn;
  // Index of the last scanline in a repeat group (N-1), from the live mode inputs
  assign last_line = bus.ang ? (bus.gm <= 3'd2 ? 4'd2 : bus.gm <= 3'd4 ? 4'd1 : 4'd0)
                             : 4'(ALPHA_ROWS - 1);
  always_comb begin
    addr_d       = addr_q;
    row_base_d   = row_base_q;
    line_count_d = line_count_q;
    if (fsn_fall) begin
      addr_d       = {bus.offset, {(ADDR_WIDTH-OFFSET_WIDTH){1'b0}}};
      row_base_d   = addr_d;
      line_count_d = 4'd0;
    end else if (hsn_fall) begin
      row_base_d   = line_count_q >= last_line ? addr_q : row_base_q;
      addr_d       = line_count_q >= last_line ? addr_q : row_base_q;
      line_count_d = line_count_q >= last_line ? 4'd0 : line_count_q + 4'd1;
    end else if (da0_fall) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
    strobe_d = fsn_fall | (addr_d != addr_q);
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q       <= '0;
      row_base_q   <= '0;
      line_count_q <= '0;
      strobe_q     <= 1'b0;
      da0_h_q      <= 1'b1;
      hsn_h_q      <= 1'b1;
      fsn_h_q      <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      row_base_q   <= row_base_d;
      line_count_q <= line_count_d;
      strobe_q     <= strobe_d;
      da0_h_q      <= bus.da0;
      hsn_h_q      <= bus.hsn;
      fsn_h_q      <= bus.fsn;
    end
  end
  assign bus.addr        = addr_q;
  assign bus.addr_strobe = strobe_q;
  assign bus.line_count  = line_count_q;
endmodule
